alu_mul_sequencer: RTL
======================

ALU_MUL_SEQUENCER -- requirements
Module: alu_mul_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_i  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port multiplicand_i  input  32  operand A, captured on start acceptance.
REQ-006 SHALL have port multiplier_i  input  32  operand B, captured on start acceptance.
REQ-007 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-008 SHALL have port done_o  output  1  one-cycle pulse, high only in state DONE.
REQ-009 SHALL have port product_o  output  32  low 32 bits of A*B, valid from DONE until the next start acceptance.
REQ-010 SHALL have port alu_op_o  output  4  ALU operation select: ADD=0000, OR=0001, SLLI=0010, SRLI=0011, SUB=0100.
REQ-011 SHALL have ports alu_a_o and alu_b_o  output  32 each  ALU operands.
REQ-012 SHALL have port alu_result_i  input  32  combinational ALU result.
REQ-013 SHALL have port alu_zero_i  input  1  ALU zero flag (result == 0).

Function
REQ-014 SHALL implement shift-add multiplication entirely through the external ALU, one ALU operation per cycle, with internal registers mc, mp, acc (32 bits each).
REQ-015 SHALL use FSM states IDLE, TEST, ACC, SHL, SHR, DONE.
REQ-016 IDLE: alu_op_o=ADD, alu_a_o=0, alu_b_o=0; on start_i=1, SHALL load mc<=multiplicand_i, mp<=multiplier_i, acc<=0, and go to TEST.
REQ-017 TEST: drive OR, a=mp, b=0; if alu_zero_i=1, go to DONE; else if mp[0]=1, go to ACC; else go to SHL.
REQ-018 ACC: drive ADD, a=acc, b=mc; acc<=alu_result_i; go to SHL.
REQ-019 SHL: drive SLLI, a=mc, b=1; mc<=alu_result_i; go to SHR.
REQ-020 SHR: drive SRLI, a=mp, b=1; mp<=alu_result_i; go to TEST.
REQ-021 DONE: drive IDLE ALU values; done_o=1; go to IDLE unconditionally.
REQ-022 product_o SHALL be driven from acc and is therefore stable from DONE until the next start acceptance.
REQ-023 Arithmetic SHALL wrap modulo 2^32; the low word is correct for both unsigned and two's-complement operands.
REQ-024 Latency from the start-acceptance edge to DONE entry SHALL be 1 + sum over set multiplier bits up to the highest set bit (4 cycles per set bit, 3 cycles per clear bit), i.e. 1 cycle for multiplier 0 and 129 cycles maximum.
REQ-025 start_i SHALL be ignored in all states other than IDLE, including DONE; start_i held high SHALL launch a new operation in the IDLE cycle after DONE.
REQ-026 Operand inputs changing while busy_o=1 SHALL NOT affect the result.

Reset
REQ-027 Asserting reset (low) SHALL immediately force IDLE, mc=mp=acc=0, busy_o=0, done_o=0, product_o=0, alu_op_o=ADD, and alu_a_o=alu_b_o=0.
REQ-028 Reset mid-operation SHALL abort the operation without producing a done_o pulse; the first start_i after release SHALL begin a fresh operation.

Structure
REQ-029 ALU operation encodings and FSM state encodings SHALL reside in a shared package alu_pkg, which the ALU also uses.
REQ-030 The block SHALL contain no sub-module; the ALU SHALL be instantiated alongside the block at the parent level and connected through the alu_* ports.

Verification (bench connects the real ALU)
REQ-031 start with multiplicand 3, multiplier 5, accepted at edge k -> DONE entered at edge k+12; done_o pulses one cycle; product_o=15.
REQ-032 multiplier 0, multiplicand 0x12345678 -> DONE at edge k+1; product_o=0.
REQ-033 multiplicand 0xFFFFFFFF, multiplier 0xFFFFFFFF -> product_o=0x00000001 after 129 cycles; multiplicand 0x80000000, multiplier 2 -> product_o=0.
REQ-034 multiplicand 0xFFFFFFFD (-3), multiplier 7 -> product_o=0xFFFFFFEB (-21).
REQ-035 Second start with new operands pulsed while busy_o=1 -> ignored; first result is unchanged; start_i held high across DONE -> next operation accepted in the following IDLE cycle.
REQ-036 reset asserted during ACC -> all outputs zero immediately; no done_o pulse; a subsequent 6*7 operation -> product_o=42.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU and the shift-add multiply sequencer.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_SLLI = 4'b0010,
        ALU_SRLI = 4'b0011,
        ALU_SUB  = 4'b0100
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TEST = 3'd1,
        ST_ACC  = 3'd2,
        ST_SHL  = 3'd3,
        ST_SHR  = 3'd4,
        ST_DONE = 3'd5
    } seq_state_t;

    // Shift amounts use only the low five bits of b, as a 32-bit shifter would.
    function automatic logic [ALU_WIDTH-1:0] alu_eval(
        input logic [3:0]           op,
        input logic [ALU_WIDTH-1:0] a,
        input logic [ALU_WIDTH-1:0] b
    );
        logic [ALU_WIDTH-1:0] r;
        r = '0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_OR:   r = a | b;
            ALU_SLLI: r = a << b[4:0];
            ALU_SRLI: r = a >> b[4:0];
            ALU_SUB:  r = a - b;
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; sits beside the multiply sequencer at the parent level.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]           op_i,
    input  logic [ALU_WIDTH-1:0] a_i,
    input  logic [ALU_WIDTH-1:0] b_i,
    output logic [ALU_WIDTH-1:0] result_o,
    output logic                 zero_o
);

    // Result and zero flag straight from the operand inputs.
    always_comb begin
        result_o = alu_eval(op_i, a_i, b_i);
        zero_o   = (result_o == '0);
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier that performs every arithmetic step on an external ALU.
//
// state | meaning
// IDLE  | waiting for start_i; ALU driven with ADD 0,0
// TEST  | OR mp,0 to detect an exhausted multiplier
// ACC   | ADD acc,mc when the multiplier LSB is set
// SHL   | SLLI mc,1
// SHR   | SRLI mp,1
// DONE  | one-cycle done_o pulse; product held in acc
//
// The ALU drive is registered, so each transition also loads the operation
// for the state being entered.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] multiplicand_i,
    input  logic [DATA_WIDTH-1:0] multiplier_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] product_o,
    output logic [3:0]            alu_op_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic                  alu_zero_i
);

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    seq_state_t            state;
    logic [DATA_WIDTH-1:0] mc;
    logic [DATA_WIDTH-1:0] mp;
    logic [DATA_WIDTH-1:0] acc;

    assign product_o = acc;

    // Sequencer state, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mc       <= '0;
            mp       <= '0;
            acc      <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            alu_op_o <= ALU_ADD;
            alu_a_o  <= '0;
            alu_b_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        mc       <= multiplicand_i;
                        mp       <= multiplier_i;
                        acc      <= '0;
                        state    <= ST_TEST;
                        busy_o   <= 1'b1;
                        alu_op_o <= ALU_OR;
                        alu_a_o  <= multiplier_i;
                        alu_b_o  <= '0;
                    end
                end
                ST_TEST: begin
                    if (alu_zero_i) begin
                        state    <= ST_DONE;
                        done_o   <= 1'b1;
                        alu_op_o <= ALU_ADD;
                        alu_a_o  <= '0;
                        alu_b_o  <= '0;
                    end else if (mp[0]) begin
                        state    <= ST_ACC;
                        alu_op_o <= ALU_ADD;
                        alu_a_o  <= acc;
                        alu_b_o  <= mc;
                    end else begin
                        state    <= ST_SHL;
                        alu_op_o <= ALU_SLLI;
                        alu_a_o  <= mc;
                        alu_b_o  <= ONE;
                    end
                end
                ST_ACC: begin
                    acc      <= alu_result_i;
                    state    <= ST_SHL;
                    alu_op_o <= ALU_SLLI;
                    alu_a_o  <= mc;
                    alu_b_o  <= ONE;
                end
                ST_SHL: begin
                    mc       <= alu_result_i;
                    state    <= ST_SHR;
                    alu_op_o <= ALU_SRLI;
                    alu_a_o  <= mp;
                    alu_b_o  <= ONE;
                end
                ST_SHR: begin
                    mp       <= alu_result_i;
                    state    <= ST_TEST;
                    alu_op_o <= ALU_OR;
                    alu_a_o  <= alu_result_i;
                    alu_b_o  <= '0;
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy_o   <= 1'b0;
                    done_o   <= 1'b0;
                    alu_op_o <= ALU_ADD;
                    alu_a_o  <= '0;
                    alu_b_o  <= '0;
                end
            endcase
        end
    end

endmodule
